// File: rtl/cva6_region_attr_unit.sv
// Runtime-programmable region attribute unit: NrRules base/length/attr entries with a
// lockable config port and a one-stage valid/ready lookup pipeline.
module cva6_region_attr_unit #(
    parameter int unsigned                   AddrWidth   = 64,
    parameter int unsigned                   NrRules     = 4,
    parameter logic [NrRules*AddrWidth-1:0]  RstAddrBase = '0,
    parameter logic [NrRules*AddrWidth-1:0]  RstLength   = '0,
    parameter logic [NrRules*4-1:0]          RstAttr     = '0,
    parameter logic [2:0]                    DefaultAttr = 3'b000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    // config access
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [3:0]           cfg_idx_i,
    input  logic [1:0]           cfg_field_i,
    input  logic [AddrWidth-1:0] cfg_wdata_i,
    output logic                 cfg_rvalid_o,
    output logic [AddrWidth-1:0] cfg_rdata_o,
    output logic                 cfg_err_o,
    // lookup request
    input  logic                 lkp_valid_i,
    output logic                 lkp_ready_o,
    input  logic [AddrWidth-1:0] lkp_addr_i,
    // lookup result
    output logic                 lkp_valid_o,
    input  logic                 lkp_ready_i,
    output logic                 lkp_hit_o,
    output logic [3:0]           lkp_rule_o,
    output logic [2:0]           lkp_attr_o
);

    localparam logic [1:0] FieldBase = 2'd0;
    localparam logic [1:0] FieldLen  = 2'd1;
    localparam logic [1:0] FieldAttr = 2'd2;
    localparam logic [1:0] FieldRsvd = 2'd3;
    localparam int unsigned LockBit  = 3;

    logic [AddrWidth-1:0] base_q [NrRules];
    logic [AddrWidth-1:0] len_q  [NrRules];
    logic [3:0]           attr_q [NrRules];

    // ------------------------------------------------------------------
    // Config decode
    // ------------------------------------------------------------------
    logic                 idx_ok;
    logic                 sel_lock;
    logic [AddrWidth-1:0] sel_rdata;
    logic                 cfg_err;
    logic                 cfg_wr;
    logic [AddrWidth-1:0] cfg_rdata_d;

    always_comb begin
        idx_ok    = 1'b0;
        sel_lock  = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NrRules; i++) begin
            if (cfg_idx_i == 4'(i)) begin
                idx_ok   = 1'b1;
                sel_lock = attr_q[i][LockBit];
                case (cfg_field_i)
                    FieldBase: sel_rdata = base_q[i];
                    FieldLen:  sel_rdata = len_q[i];
                    FieldAttr: sel_rdata = AddrWidth'(attr_q[i]);
                    default:   sel_rdata = '0;
                endcase
            end
        end
        // Lock only blocks writes; locked rules stay readable.
        cfg_err     = !idx_ok || (cfg_field_i == FieldRsvd) || (cfg_we_i && sel_lock);
        cfg_wr      = cfg_req_i && cfg_we_i && !cfg_err;
        cfg_rdata_d = (cfg_req_i && !cfg_we_i && !cfg_err) ? sel_rdata : '0;
    end

    // ------------------------------------------------------------------
    // Rule storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NrRules; i++) begin
                base_q[i] <= RstAddrBase[i*AddrWidth +: AddrWidth];
                len_q[i]  <= RstLength[i*AddrWidth +: AddrWidth];
                attr_q[i] <= RstAttr[i*4 +: 4];
            end
        end else if (cfg_wr) begin
            for (int unsigned i = 0; i < NrRules; i++) begin
                if (cfg_idx_i == 4'(i)) begin
                    case (cfg_field_i)
                        FieldBase: base_q[i] <= cfg_wdata_i;
                        FieldLen:  len_q[i]  <= cfg_wdata_i;
                        FieldAttr: attr_q[i] <= cfg_wdata_i[3:0];
                        default:   ;
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Config response register
    // ------------------------------------------------------------------
    logic                 cfg_rvalid_q;
    logic                 cfg_err_q;
    logic [AddrWidth-1:0] cfg_rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_rvalid_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            cfg_rdata_q  <= '0;
        end else begin
            cfg_rvalid_q <= cfg_req_i;
            cfg_err_q    <= cfg_req_i && cfg_err;
            cfg_rdata_q  <= cfg_rdata_d;
        end
    end

    assign cfg_rvalid_o = cfg_rvalid_q;
    assign cfg_err_o    = cfg_err_q;
    assign cfg_rdata_o  = cfg_rdata_q;

    // ------------------------------------------------------------------
    // Address match
    // ------------------------------------------------------------------
    logic [NrRules-1:0] rule_match;
    logic               match_hit;
    logic [3:0]         match_rule;
    logic [2:0]         match_attr;

    // End address is one bit wider so regions touching the top of the space do not wrap.
    always_comb begin
        rule_match = '0;
        for (int unsigned i = 0; i < NrRules; i++) begin
            rule_match[i] = (len_q[i] != '0)
                         && (lkp_addr_i >= base_q[i])
                         && ({1'b0, lkp_addr_i} < ({1'b0, base_q[i]} + {1'b0, len_q[i]}));
        end
    end

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        match_hit  = 1'b0;
        match_rule = '0;
        match_attr = DefaultAttr;
        for (int i = int'(NrRules) - 1; i >= 0; i--) begin
            if (rule_match[i]) begin
                match_hit  = 1'b1;
                match_rule = 4'(i);
                match_attr = attr_q[i][2:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Lookup output register
    // ------------------------------------------------------------------
    logic       lkp_valid_q;
    logic       lkp_hit_q;
    logic [3:0] lkp_rule_q;
    logic [2:0] lkp_attr_q;
    logic       lkp_accept;

    assign lkp_ready_o = !lkp_valid_q || lkp_ready_i;
    assign lkp_accept  = lkp_valid_i && lkp_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lkp_valid_q <= 1'b0;
            lkp_hit_q   <= 1'b0;
            lkp_rule_q  <= '0;
            lkp_attr_q  <= DefaultAttr;
        end else begin
            if (lkp_ready_o) begin
                lkp_valid_q <= lkp_valid_i;
            end
            if (lkp_accept) begin
                lkp_hit_q  <= match_hit;
                lkp_rule_q <= match_rule;
                lkp_attr_q <= match_attr;
            end
        end
    end

    assign lkp_valid_o = lkp_valid_q;
    assign lkp_hit_o   = lkp_hit_q;
    assign lkp_rule_o  = lkp_rule_q;
    assign lkp_attr_o  = lkp_attr_q;

endmodule

// File: tb/tb_cva6_region_attr_unit.sv
// Self-checking bench for cva6_region_attr_unit: vector tables, hand-written corner
// sequences and a randomized phase checked against a behavioural rule model.
module tb_cva6_region_attr_unit;

    localparam int unsigned AW = 64;
    localparam int unsigned NR = 4;
    localparam logic [NR*AW-1:0] RST_BASE = {64'h0, 64'h0, 64'h0, 64'h8000_0000};
    localparam logic [NR*AW-1:0] RST_LEN  = {64'h0, 64'h0, 64'h0, 64'h4000_0000};
    localparam logic [NR*4-1:0]  RST_ATTR = {4'h0, 4'h0, 4'h0, 4'h3};
    localparam logic [2:0]       DEF_ATTR = 3'b100;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b1;
    logic          cfg_req = 1'b0;
    logic          cfg_we = 1'b0;
    logic [3:0]    cfg_idx = '0;
    logic [1:0]    cfg_field = '0;
    logic [AW-1:0] cfg_wdata = '0;
    logic          cfg_rvalid;
    logic [AW-1:0] cfg_rdata;
    logic          cfg_err;
    logic          lkp_valid_i = 1'b0;
    logic          lkp_ready_o;
    logic [AW-1:0] lkp_addr = '0;
    logic          lkp_valid_o;
    logic          lkp_ready_i = 1'b1;
    logic          lkp_hit;
    logic [3:0]    lkp_rule;
    logic [2:0]    lkp_attr;

    cva6_region_attr_unit #(
        .AddrWidth  (AW),
        .NrRules    (NR),
        .RstAddrBase(RST_BASE),
        .RstLength  (RST_LEN),
        .RstAttr    (RST_ATTR),
        .DefaultAttr(DEF_ATTR)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .cfg_req_i   (cfg_req),
        .cfg_we_i    (cfg_we),
        .cfg_idx_i   (cfg_idx),
        .cfg_field_i (cfg_field),
        .cfg_wdata_i (cfg_wdata),
        .cfg_rvalid_o(cfg_rvalid),
        .cfg_rdata_o (cfg_rdata),
        .cfg_err_o   (cfg_err),
        .lkp_valid_i (lkp_valid_i),
        .lkp_ready_o (lkp_ready_o),
        .lkp_addr_i  (lkp_addr),
        .lkp_valid_o (lkp_valid_o),
        .lkp_ready_i (lkp_ready_i),
        .lkp_hit_o   (lkp_hit),
        .lkp_rule_o  (lkp_rule),
        .lkp_attr_o  (lkp_attr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       hit;
        logic [3:0] rule;
        logic [2:0] attr;
    } res_t;

    typedef struct {
        logic [63:0] addr;
        logic        hit;
        logic [3:0]  rule;
        logic [2:0]  attr;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] m_base [NR];
    logic [63:0] m_len  [NR];
    logic [3:0]  m_attr [NR];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_base[i] = 64'h0;
            m_len[i]  = 64'h0;
            m_attr[i] = 4'h0;
        end
        m_base[0] = 64'h8000_0000;
        m_len[0]  = 64'h4000_0000;
        m_attr[0] = 4'h3;
    endtask

    // First rule (lowest index) whose [base, base+len) range holds the address.
    function automatic res_t model_lookup(input logic [63:0] a);
        res_t r;
        r.hit  = 1'b0;
        r.rule = 4'd0;
        r.attr = DEF_ATTR;
        for (int i = 0; i < NR; i++) begin
            if (m_len[i] != 0 && a >= m_base[i] && (a - m_base[i]) < m_len[i]) begin
                r.hit  = 1'b1;
                r.rule = 4'(i);
                r.attr = m_attr[i][2:0];
                return r;
            end
        end
        return r;
    endfunction

    // One config access; expected response derived from the model.
    task automatic cfg(input logic we, input logic [3:0] idx, input logic [1:0] field,
                       input logic [63:0] wdata, input string name);
        logic        exp_err;
        logic [63:0] exp_rd;
        exp_err = 1'b1;
        exp_rd  = 64'h0;
        if (idx < 4'(NR) && field != 2'd3) begin
            exp_err = we && m_attr[idx[1:0]][3];
            if (!we && !exp_err) begin
                case (field)
                    2'd0:    exp_rd = m_base[idx[1:0]];
                    2'd1:    exp_rd = m_len[idx[1:0]];
                    default: exp_rd = {60'h0, m_attr[idx[1:0]]};
                endcase
            end
        end
        cfg_req   = 1'b1;
        cfg_we    = we;
        cfg_idx   = idx;
        cfg_field = field;
        cfg_wdata = wdata;
        tick();
        cfg_req = 1'b0;
        cfg_we  = 1'b0;
        if (we && !exp_err) begin
            case (field)
                2'd0:    m_base[idx[1:0]] = wdata;
                2'd1:    m_len[idx[1:0]]  = wdata;
                default: m_attr[idx[1:0]] = wdata[3:0];
            endcase
        end
        check({name, " rvalid"}, cfg_rvalid, 1'b1);
        check({name, " err"}, cfg_err, exp_err);
        if (!we) check({name, " rdata"}, cfg_rdata, exp_rd);
    endtask

    task automatic lookup_chk(input logic [63:0] a, input logic eh, input logic [3:0] er,
                              input logic [2:0] ea, input string name);
        lkp_valid_i = 1'b1;
        lkp_addr    = a;
        lkp_ready_i = 1'b1;
        tick();
        lkp_valid_i = 1'b0;
        check({name, " valid"}, lkp_valid_o, 1'b1);
        check({name, " hit"}, lkp_hit, eh);
        check({name, " rule"}, lkp_rule, er);
        check({name, " attr"}, lkp_attr, ea);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab1[9];
        vec_t tab2[5];
        res_t q[$];
        logic prev_cfg;
        logic exp_ready;
        logic do_wr;

        model_reset();
        #1 rst_ni = 1'b0;
        tick();
        tick();
        check("rst lkp_valid_o", lkp_valid_o, 1'b0);
        check("rst lkp_hit", lkp_hit, 1'b0);
        check("rst lkp_rule", lkp_rule, 4'd0);
        check("rst lkp_attr", lkp_attr, DEF_ATTR);
        check("rst lkp_ready_o", lkp_ready_o, 1'b1);
        check("rst cfg_rvalid", cfg_rvalid, 1'b0);
        check("rst cfg_err", cfg_err, 1'b0);
        check("rst cfg_rdata", cfg_rdata, 64'h0);
        rst_ni = 1'b1;
        tick();

        lookup_chk(64'h9000_0000, 1'b1, 4'd0, 3'b011, "rst rule0");
        cfg(1'b0, 4'd0, 2'd0, 64'h0, "rd r0 base");
        cfg(1'b0, 4'd0, 2'd1, 64'h0, "rd r0 len");
        cfg(1'b0, 4'd0, 2'd2, 64'h0, "rd r0 attr");
        tick();
        check("cfg rvalid one cycle", cfg_rvalid, 1'b0);

        // Overlapping rules plus a region at the top of the address space.
        cfg(1'b1, 4'd0, 2'd0, 64'h1000, "wr r0 base");
        cfg(1'b1, 4'd0, 2'd1, 64'h100, "wr r0 len");
        cfg(1'b1, 4'd0, 2'd2, 64'h1, "wr r0 attr");
        cfg(1'b1, 4'd1, 2'd0, 64'h0, "wr r1 base");
        cfg(1'b1, 4'd1, 2'd1, 64'h10000, "wr r1 len");
        cfg(1'b1, 4'd1, 2'd2, 64'hFFFF_FFF2, "wr r1 attr");
        cfg(1'b0, 4'd1, 2'd2, 64'h0, "rd r1 attr");
        cfg(1'b1, 4'd3, 2'd0, 64'hFFFF_FFFF_FFFF_F000, "wr r3 base");
        cfg(1'b1, 4'd3, 2'd1, 64'h1000, "wr r3 len");
        cfg(1'b1, 4'd3, 2'd2, 64'h6, "wr r3 attr");

        tab1[0] = '{64'h1080, 1'b1, 4'd0, 3'b001};
        tab1[1] = '{64'h2000, 1'b1, 4'd1, 3'b010};
        tab1[2] = '{64'h20000, 1'b0, 4'd0, DEF_ATTR};
        tab1[3] = '{64'h10FF, 1'b1, 4'd0, 3'b001};
        tab1[4] = '{64'h1100, 1'b1, 4'd1, 3'b010};
        tab1[5] = '{64'h0FFF, 1'b1, 4'd1, 3'b010};
        tab1[6] = '{64'h10000, 1'b0, 4'd0, DEF_ATTR};
        tab1[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd3, 3'b110};
        tab1[8] = '{64'hFFFF_FFFF_FFFF_EFFF, 1'b0, 4'd0, DEF_ATTR};
        for (int i = 0; i < 9; i++) begin
            lookup_chk(tab1[i].addr, tab1[i].hit, tab1[i].rule, tab1[i].attr,
                       $sformatf("tab1[%0d]", i));
        end

        cfg(1'b1, 4'd1, 2'd1, 64'h0, "dis r1");
        tab2[0] = '{64'h0, 1'b0, 4'd0, DEF_ATTR};
        tab2[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd3, 3'b110};
        tab2[2] = '{64'hFFFF_FFFF_FFFF_F000, 1'b1, 4'd3, 3'b110};
        tab2[3] = '{64'h1000, 1'b1, 4'd0, 3'b001};
        tab2[4] = '{64'h2000, 1'b0, 4'd0, DEF_ATTR};
        for (int i = 0; i < 5; i++) begin
            lookup_chk(tab2[i].addr, tab2[i].hit, tab2[i].rule, tab2[i].attr,
                       $sformatf("tab2[%0d]", i));
        end
        tick();

        // Backpressure: A held for 3 stalled cycles, B queued behind it.
        lkp_ready_i = 1'b0;
        lkp_valid_i = 1'b1;
        lkp_addr    = 64'h1080;
        tick();
        lkp_addr = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            check("bp valid", lkp_valid_o, 1'b1);
            check("bp rule", lkp_rule, 4'd0);
            check("bp attr", lkp_attr, 3'b001);
            check("bp ready_o", lkp_ready_o, 1'b0);
            tick();
        end
        lkp_ready_i = 1'b1;
        #1 check("bp release ready_o", lkp_ready_o, 1'b1);
        tick();
        lkp_valid_i = 1'b0;
        check("bp B valid", lkp_valid_o, 1'b1);
        check("bp B hit", lkp_hit, 1'b1);
        check("bp B rule", lkp_rule, 4'd3);
        check("bp B attr", lkp_attr, 3'b110);
        tick();
        check("bp drained", lkp_valid_o, 1'b0);

        // Randomized stream with backpressure and concurrent rule rewrites.
        prev_cfg = 1'b0;
        for (int c = 0; c < 400; c++) begin
            check("rnd cfg_rvalid", cfg_rvalid, prev_cfg);
            if (prev_cfg) check("rnd cfg_err", cfg_err, 1'b0);
            check("rnd lkp_valid_o", lkp_valid_o, q.size() != 0);
            if (q.size() != 0) begin
                check("rnd hit", lkp_hit, q[0].hit);
                check("rnd rule", lkp_rule, q[0].rule);
                check("rnd attr", lkp_attr, q[0].attr);
            end
            lkp_valid_i = ($urandom_range(0, 3) != 0);
            lkp_ready_i = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) != 0) lkp_addr = 64'($urandom_range(0, 'h1FFFF));
            else                           lkp_addr = {$urandom, $urandom};
            do_wr     = ($urandom_range(0, 3) == 0);
            cfg_req   = do_wr;
            cfg_we    = do_wr;
            cfg_idx   = 4'($urandom_range(0, 1));
            cfg_field = 2'($urandom_range(0, 2));
            case (cfg_field)
                2'd0:    cfg_wdata = 64'($urandom_range(0, 'h1FFFF));
                2'd1:    cfg_wdata = 64'($urandom_range(0, 'h8000));
                default: cfg_wdata = 64'($urandom_range(0, 7));
            endcase
            #1;
            exp_ready = (q.size() == 0) || lkp_ready_i;
            check("rnd ready_o", lkp_ready_o, exp_ready);
            if (q.size() != 0 && lkp_ready_i) void'(q.pop_front());
            if (lkp_valid_i && exp_ready) q.push_back(model_lookup(lkp_addr));
            if (do_wr) begin
                case (cfg_field)
                    2'd0:    m_base[cfg_idx[1:0]] = cfg_wdata;
                    2'd1:    m_len[cfg_idx[1:0]]  = cfg_wdata;
                    default: m_attr[cfg_idx[1:0]] = cfg_wdata[3:0];
                endcase
            end
            prev_cfg = do_wr;
            tick();
        end
        cfg_req     = 1'b0;
        cfg_we      = 1'b0;
        lkp_valid_i = 1'b0;
        lkp_ready_i = 1'b1;
        tick();
        tick();

        // Lock behaviour on rule 2.
        cfg(1'b1, 4'd2, 2'd0, 64'h5000, "lk base wr");
        cfg(1'b1, 4'd2, 2'd2, 64'hF, "lk attr wr");
        cfg(1'b0, 4'd2, 2'd2, 64'h0, "lk attr rd");
        cfg(1'b1, 4'd2, 2'd0, 64'h7000, "lk base wr locked");
        cfg(1'b0, 4'd2, 2'd0, 64'h0, "lk base rd");
        cfg(1'b1, 4'd2, 2'd2, 64'h0, "lk unlock wr");
        cfg(1'b0, 4'd2, 2'd2, 64'h0, "lk attr rd2");
        cfg(1'b1, 4'(NR), 2'd0, 64'h1234, "bad idx wr");
        cfg(1'b0, 4'(NR), 2'd0, 64'h0, "bad idx rd");
        cfg(1'b0, 4'd0, 2'd3, 64'h0, "rsvd field rd");

        // Same-cycle write and lookup: lookup sees pre-write rules.
        cfg(1'b1, 4'd0, 2'd0, 64'h1000, "sc r0 base");
        cfg(1'b1, 4'd0, 2'd1, 64'h100, "sc r0 len");
        cfg(1'b1, 4'd0, 2'd2, 64'h1, "sc r0 attr");
        cfg(1'b1, 4'd1, 2'd1, 64'h0, "sc r1 len");
        cfg_req     = 1'b1;
        cfg_we      = 1'b1;
        cfg_idx     = 4'd0;
        cfg_field   = 2'd1;
        cfg_wdata   = 64'h0;
        lkp_valid_i = 1'b1;
        lkp_addr    = 64'h1080;
        tick();
        cfg_req = 1'b0;
        cfg_we  = 1'b0;
        m_len[0] = 64'h0;
        check("sc same hit", lkp_hit, 1'b1);
        check("sc same rule", lkp_rule, 4'd0);
        tick();
        lkp_valid_i = 1'b0;
        check("sc next valid", lkp_valid_o, 1'b1);
        check("sc next hit", lkp_hit, 1'b0);
        check("sc next attr", lkp_attr, DEF_ATTR);
        tick();

        // Reset mid-transaction drops the held result and restores locked rules.
        lkp_ready_i = 1'b0;
        lkp_valid_i = 1'b1;
        lkp_addr    = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        check("mr held valid", lkp_valid_o, 1'b1);
        #2 rst_ni = 1'b0;
        #1;
        check("mr valid", lkp_valid_o, 1'b0);
        check("mr hit", lkp_hit, 1'b0);
        check("mr rule", lkp_rule, 4'd0);
        check("mr attr", lkp_attr, DEF_ATTR);
        lkp_valid_i = 1'b0;
        lkp_ready_i = 1'b1;
        tick();
        rst_ni = 1'b1;
        model_reset();
        tick();
        cfg(1'b0, 4'd2, 2'd2, 64'h0, "mr r2 attr");
        cfg(1'b0, 4'd0, 2'd0, 64'h0, "mr r0 base");
        cfg(1'b1, 4'd2, 2'd0, 64'h1234, "mr r2 base wr");
        lookup_chk(64'h9000_0000, 1'b1, 4'd0, 3'b011, "mr rule0");
        lookup_chk(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd0, DEF_ATTR, "mr top miss");
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
